// File: rtl/reg_bank_param.sv
// Instruction-driven register bank: 2**DEPTH_LOG2 registers of WIDTH bits,
// one instruction per cycle, with the selected register exposed on out.
module reg_bank_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [4+DEPTH_LOG2+WIDTH-1:0]   inst,
    input  logic                            inst_en,
    output logic [WIDTH-1:0]                out,
    output logic                            ready,
    output logic                            error
);

    localparam int DEPTH      = 2 ** DEPTH_LOG2;
    localparam int INST_WIDTH = 4 + DEPTH_LOG2 + WIDTH;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_RDO = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_CLR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   out_sel_q, out_sel_d;
    logic [WIDTH-1:0]        regs_q [DEPTH];
    logic [WIDTH-1:0]        regs_d [DEPTH];

    logic [3:0]              code;
    logic [DEPTH_LOG2-1:0]   sel;
    logic [WIDTH-1:0]        imm;
    logic [DEPTH_LOG2-1:0]   mov_src;

    assign code    = inst[INST_WIDTH-1 -: 4];
    assign sel     = inst[WIDTH +: DEPTH_LOG2];
    assign imm     = inst[WIDTH-1:0];
    assign mov_src = imm[DEPTH_LOG2-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RESET;
            out_sel_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            out_sel_q <= out_sel_d;
            regs_q    <= regs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_sel_d = out_sel_q;
        regs_d    = regs_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_READY;
            end
            ST_READY: begin
                if (inst_en) begin
                    case (code)
                        OP_NOP: ;
                        OP_RDO: out_sel_d   = sel;
                        OP_LD:  regs_d[sel] = imm;
                        OP_INC: regs_d[sel] = regs_q[sel] + WIDTH'(1);
                        OP_DEC: regs_d[sel] = regs_q[sel] - WIDTH'(1);
                        OP_CLR: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                regs_d[i] = '0;
                            end
                        end
                        // Source is read from pre-edge state, so sel==src is a no-op.
                        OP_MOV: regs_d[sel] = regs_q[mov_src];
                        default: begin
                            state_d   = ST_ERROR;
                            out_sel_d = '0;
                            for (int i = 0; i < DEPTH; i++) begin
                                regs_d[i] = '0;
                            end
                        end
                    endcase
                end
            end
            default: begin
                // ERROR and the unreachable encoding both park here until reset.
                state_d   = ST_ERROR;
                out_sel_d = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    regs_d[i] = '0;
                end
            end
        endcase
    end

    assign out   = regs_q[out_sel_q];
    assign ready = (state_q == ST_READY);
    assign error = (state_q != ST_RESET) && (state_q != ST_READY);

`ifdef SIM
    string state_str;
    string op_str;

    always_comb begin
        case (state_q)
            ST_RESET: state_str = "RESET";
            ST_READY: state_str = "READY";
            default:  state_str = "ERROR";
        endcase
        if (!inst_en) begin
            op_str = "----";
        end else begin
            case (code)
                OP_NOP:  op_str = "NOP";
                OP_RDO:  op_str = "RDO";
                OP_LD:   op_str = "LD";
                OP_INC:  op_str = "INC";
                OP_DEC:  op_str = "DEC";
                OP_CLR:  op_str = "CLR";
                OP_MOV:  op_str = "MOV";
                default: op_str = "ILLEGAL";
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param (WIDTH=8, DEPTH_LOG2=2): directed scenarios plus
// randomized instruction streams compared against a behavioural model.
module tb_reg_bank_param;

    localparam int W  = 8;
    localparam int DL = 2;
    localparam int D  = 4;
    localparam int IW = 4 + DL + W;

    logic          clock = 1'b0;
    logic          reset;
    logic          inst_en;
    logic [IW-1:0] inst;
    logic [W-1:0]  out;
    logic          ready;
    logic          error;

    always #5 clock = ~clock;

    reg_bank_param #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .out     (out),
        .ready   (ready),
        .error   (error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0=RESET, 1=READY, 2=ERROR
    int m_state = 0;
    int m_regs [D];
    int m_sel = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [IW-1:0] mk(input int code, input int sel, input int imm);
        logic [3:0]    c;
        logic [DL-1:0] s;
        logic [W-1:0]  i;
        c = code[3:0];
        s = sel[DL-1:0];
        i = imm[W-1:0];
        return {c, s, i};
    endfunction

    task automatic model_step(input bit r, input bit e, input logic [IW-1:0] ins);
        int code, sel, imm;
        code = int'(ins[IW-1 -: 4]);
        sel  = int'(ins[W +: DL]);
        imm  = int'(ins[W-1:0]);
        if (r) begin
            m_state = 0;
            m_sel   = 0;
            foreach (m_regs[k]) m_regs[k] = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && e) begin
            if (code == 1) m_sel = sel;
            else if (code == 2) m_regs[sel] = imm;
            else if (code == 3) m_regs[sel] = (m_regs[sel] + 1) % (1 << W);
            else if (code == 4) m_regs[sel] = (m_regs[sel] + (1 << W) - 1) % (1 << W);
            else if (code == 5) foreach (m_regs[k]) m_regs[k] = 0;
            else if (code == 6) m_regs[sel] = m_regs[imm % D];
            else if (code >= 7) begin
                m_state = 2;
                m_sel   = 0;
                foreach (m_regs[k]) m_regs[k] = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input logic [IW-1:0] ins, input string tag);
        reset   = r;
        inst_en = e;
        inst    = ins;
        @(posedge clock);
        model_step(r, e, ins);
        #1;
        check({tag, ".out"},   int'(out),   m_regs[m_sel]);
        check({tag, ".ready"}, int'(ready), (m_state == 1) ? 1 : 0);
        check({tag, ".error"}, int'(error), (m_state == 2) ? 1 : 0);
    endtask

    initial begin
        reset   = 1'b1;
        inst_en = 1'b0;
        inst    = '0;

        // Reset then idle: ready rises one edge later
        cyc(1, 0, '0, "rst");
        check("t1.ready0", int'(ready), 0);
        check("t1.out0",   int'(out),   0);
        cyc(0, 0, '0, "idle1");
        check("t1.ready1", int'(ready), 1);

        // Load and read back
        cyc(0, 1, mk(2, 2, 'hA5), "ld2");
        cyc(0, 1, mk(1, 2, 0),    "rdo2");
        check("t2.a5", int'(out), 'hA5);
        cyc(0, 1, mk(2, 2, 'h3C), "ld2b");
        check("t2.3c", int'(out), 'h3C);

        // Increment / decrement wrap
        cyc(0, 1, mk(2, 1, 'hFF), "ld1");
        cyc(0, 1, mk(1, 1, 0),    "rdo1");
        cyc(0, 1, mk(3, 1, 0),    "inc1");
        check("t3.incwrap", int'(out), 'h00);
        cyc(0, 1, mk(4, 1, 0),    "dec1");
        check("t3.dec", int'(out), 'hFF);
        cyc(0, 1, mk(4, 0, 0),    "dec0");
        cyc(0, 1, mk(1, 0, 0),    "rdo0");
        check("t3.decwrap", int'(out), 'hFF);

        // Move and clear
        cyc(0, 1, mk(2, 3, 'h5A), "ld3");
        cyc(0, 1, mk(6, 0, 'hF3), "mov");
        check("t4.mov", int'(out), 'h5A);
        cyc(0, 1, mk(5, 0, 0),    "clr");
        check("t4.clr", int'(out), 0);
        check("t4.rdy", int'(ready), 1);
        cyc(0, 1, mk(2, 0, 'h11), "ldafterclr");
        check("t4.sel0", int'(out), 'h11);

        // Reset beats a simultaneous load; disabled illegal opcode is harmless
        cyc(1, 1, mk(2, 0, 'h77), "rstld");
        check("t6.r0", int'(out), 0);
        cyc(0, 0, '0, "idle2");
        cyc(0, 0, mk(9, 0, 0), "ill_off");
        check("t6.noerr", int'(error), 0);

        // Illegal opcode, sticky error, reset recovery
        cyc(0, 1, mk(2, 0, 'h42), "ldpre");
        cyc(0, 1, mk(9, 0, 0),    "ill");
        check("t5.err", int'(error), 1);
        check("t5.out", int'(out), 0);
        cyc(0, 1, mk(2, 0, 'h33), "lderr");
        check("t5.sticky", int'(error), 1);
        check("t5.out2", int'(out), 0);
        cyc(1, 0, '0, "rst2");
        check("t5.rst_err", int'(error), 0);
        cyc(0, 0, '0, "idle3");
        check("t5.rdy", int'(ready), 1);

        // Randomized stream
        for (int n = 0; n < 800; n++) begin
            bit r, e;
            int code;
            r = ($urandom % 40) == 0;
            e = ($urandom % 4) != 0;
            if (($urandom % 40) == 0) code = $urandom_range(7, 15);
            else code = $urandom_range(0, 6);
            cyc(r, e, mk(code, $urandom_range(0, D - 1), $urandom_range(0, 255)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
